reduce_sweep_gate: RTL and testbench

Parametrised, clocked successor to the 3-input combinational OR lab gate.
- Selectable N-input reduction function: OR, AND, XOR or NOR.
- On a start request, it sweeps all 2^N input combinations, one per clock, and evaluates the function on each.
- Results are captured into a truth-table register and a ones count, so the lab bench checks a whole gate in one run instead of stepping inputs by hand.

---
 rtl/reduce_sweep_gate.sv | 127 ++++++++++++
 tb/tb_reduce_sweep_gate.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reduce_sweep_gate.sv
// N-input reduction gate (OR/AND/XOR/NOR) that sweeps every input vector once per start
// and records the results as a truth table and a ones count.
module reduce_sweep_gate #(
   parameter int N = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   output logic [N-1:0]          x,
   output logic                  f,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<N)-1:0]     tt,
   output logic [N:0]            ones
);

   // state | meaning
   // IDLE  | waiting for start; done pulses here for one cycle after a sweep
   // SWEEP | evaluating vector x, one per clock, until x reaches 2^N-1

   localparam int W  = 1 << N;
   localparam int CW = N + 1;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [N-1:0]    x_q, x_d;
   logic            f_q, f_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W-1:0]    tt_q, tt_d;
   logic [CW-1:0]   ones_q, ones_d;
   logic            fn_val;
   logic            last_vec;

   always_comb begin
      fn_val = 1'b0;
      case (mode_q)
         2'b00:   fn_val = |x_q;
         2'b01:   fn_val = &x_q;
         2'b10:   fn_val = ^x_q;
         default: fn_val = ~(|x_q);
      endcase
   end

   assign last_vec = (x_q == {N{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SWEEP;
         SWEEP:   if (last_vec) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mode and start are only looked at in IDLE; a sweep always runs to completion on mode_q
   always_comb begin
      mode_d = mode_q;
      x_d    = x_q;
      f_d    = f_q;
      busy_d = busy_q;
      done_d = 1'b0;
      tt_d   = tt_q;
      ones_d = ones_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = mode;
               x_d    = '0;
               f_d    = 1'b0;
               busy_d = 1'b1;
               tt_d   = '0;
               ones_d = '0;
            end
         end
         SWEEP: begin
            tt_d[x_q] = fn_val;
            f_d       = fn_val;
            ones_d    = ones_q + CW'(fn_val);
            if (last_vec) begin
               x_d    = '0;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               x_d = x_q + N'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 2'b00;
         x_q    <= '0;
         f_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         tt_q   <= '0;
         ones_q <= '0;
      end else begin
         mode_q <= mode_d;
         x_q    <= x_d;
         f_q    <= f_d;
         busy_q <= busy_d;
         done_q <= done_d;
         tt_q   <= tt_d;
         ones_q <= ones_d;
      end
   end

   assign x    = x_q;
   assign f    = f_q;
   assign busy = busy_q;
   assign done = done_q;
   assign tt   = tt_q;
   assign ones = ones_q;

endmodule

// File: tb/tb_reduce_sweep_gate.sv
// Directed bench for reduce_sweep_gate: N=3 main instance plus N=1 and N=8 corner instances.
module tb_reduce_sweep_gate;

   logic clk, rst;

   logic       start3, start1, start8;
   logic [1:0] mode3, mode1, mode8;

   logic [2:0]   x3;   logic f3, busy3, done3;   logic [7:0]   tt3;  logic [3:0] ones3;
   logic [0:0]   x1;   logic f1, busy1, done1;   logic [1:0]   tt1;  logic [1:0] ones1;
   logic [7:0]   x8;   logic f8, busy8, done8;   logic [255:0] tt8;  logic [8:0] ones8;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int cyc;
   logic [255:0] exp8;

   reduce_sweep_gate #(.N(3)) u3 (.clk(clk), .rst(rst), .start(start3), .mode(mode3),
      .x(x3), .f(f3), .busy(busy3), .done(done3), .tt(tt3), .ones(ones3));
   reduce_sweep_gate #(.N(1)) u1 (.clk(clk), .rst(rst), .start(start1), .mode(mode1),
      .x(x1), .f(f1), .busy(busy1), .done(done1), .tt(tt1), .ones(ones1));
   reduce_sweep_gate #(.N(8)) u8 (.clk(clk), .rst(rst), .start(start8), .mode(mode8),
      .x(x8), .f(f8), .busy(busy8), .done(done8), .tt(tt8), .ones(ones8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start a sweep on u3, wait for done, check latency and results
   task automatic run3(input logic [1:0] m, input logic [7:0] e_tt, input logic [3:0] e_ones,
                       input string tag);
      int c;
      mode3 = m; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      c = 0;
      while (!done3 && c < 40) begin tick(); c++; end
      check({tag, " latency"}, c, 8);
      check({tag, " tt"}, tt3, e_tt);
      check({tag, " ones"}, ones3, e_ones);
      check({tag, " busy"}, busy3, 0);
      check({tag, " x"}, x3, 0);
      tick();
      check({tag, " done clr"}, done3, 0);
      check({tag, " tt hold"}, tt3, e_tt);
   endtask

   initial begin
      rst = 1'b1;
      start3 = 0; start1 = 0; start8 = 0;
      mode3 = 0;  mode1 = 0;  mode8 = 0;
      #12;
      check("rst x", x3, 0);
      check("rst busy", busy3, 0);
      check("rst done", done3, 0);
      check("rst tt", tt3, 0);
      check("rst ones", ones3, 0);
      check("rst f", f3, 0);
      rst = 1'b0;
      tick();

      // scenario 1: OR sweep, busy high for all 8 evaluation cycles
      mode3 = 2'b00; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("s1 busy", busy3, 1);
         check("s1 done low", done3, 0);
         tick();
      end
      check("s1 done", done3, 1);
      check("s1 tt", tt3, 8'hFE);
      check("s1 ones", ones3, 7);
      check("s1 x", x3, 0);
      check("s1 busy end", busy3, 0);
      check("s1 f", f3, 1);
      tick();
      check("s1 done clr", done3, 0);

      // scenario 2: remaining modes
      run3(2'b01, 8'h80, 4'd1, "s2 and");
      run3(2'b10, 8'h96, 4'd4, "s2 xor");
      run3(2'b11, 8'h01, 4'd1, "s2 nor");

      // scenario 3: mid-sweep mode change and start are ignored
      mode3 = 2'b00; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      tick(); tick(); tick();
      mode3 = 2'b01; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      check("s3 x mid", x3, 4);
      cyc = 4;
      while (!done3 && cyc < 40) begin tick(); cyc++; end
      check("s3 latency", cyc, 8);
      check("s3 tt", tt3, 8'hFE);
      check("s3 ones", ones3, 7);
      tick();
      check("s3 no restart", busy3, 0);

      // scenario 4: async reset between edges at x=4
      mode3 = 2'b00; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      tick(); tick(); tick(); tick();
      check("s4 x pre", x3, 4);
      check("s4 tt pre", tt3, 8'h0E);
      #2 rst = 1'b1;
      #1;
      check("s4 x", x3, 0);
      check("s4 busy", busy3, 0);
      check("s4 tt", tt3, 0);
      check("s4 ones", ones3, 0);
      check("s4 done", done3, 0);
      #1 rst = 1'b0;
      tick();
      run3(2'b10, 8'h96, 4'd4, "s4 fresh");

      // scenario 5: start held high, back-to-back XOR sweeps
      mode3 = 2'b10; start3 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("s5 done", done3, (k == 8 || k == 17));
         check("s5 busy", busy3, !(k == 8 || k == 17));
         if (k == 8 || k == 17) check("s5 tt", tt3, 8'h96);
         if (k == 8 || k == 17) check("s5 ones", ones3, 4);
      end
      start3 = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      tick();

      // scenario 6a: N=1 XOR
      mode1 = 2'b10; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 10) begin tick(); cyc++; end
      check("n1 latency", cyc, 2);
      check("n1 tt", tt1, 2'b10);
      check("n1 ones", ones1, 1);
      check("n1 x", x1, 0);

      // scenario 6b: N=8 AND
      mode8 = 2'b01; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 400) begin tick(); cyc++; end
      exp8 = '0;
      exp8[255] = 1'b1;
      check("n8 latency", cyc, 256);
      check("n8 tt", tt8, exp8);
      check("n8 ones", ones8, 1);
      check("n8 busy", busy8, 0);
      tick();
      check("n8 done clr", done8, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
